mem_port_arbiter: RTL and testbench

- Shares one single-ported 32-bit memory between two requesters: instruction fetch (A, read-only) and data load/store (B).
- Drives the select of the 32-bit 2:1 address/write-data mux in front of the memory, plus the memory enable and write enable.
- Sequences fixed-latency accesses, captures read data and returns a one-cycle acknowledge to the granted requester.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported 32-bit memory.
// Requester A (instruction fetch) is read-only; requester B (data) can read or write.
// Each access holds MemEn for LATENCY cycles, then returns a one-cycle Ack to
// the granted requester. When both requesters wait, the grant alternates
// (round-robin), starting with B after reset. Every output is registered.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqA,
  input  logic        ReqB,
  input  logic        WeB,
  input  logic [31:0] MemRData,
  output logic        Sel,
  output logic        MemEn,
  output logic        MemWe,
  output logic        AckA,
  output logic        AckB,
  output logic [31:0] RData,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lastGrantB_q, lastGrantB_d;
  logic               sel_q, sel_d;
  logic               memEn_q, memEn_d;
  logic               memWe_q, memWe_d;
  logic               ackA_q, ackA_d;
  logic               ackB_q, ackB_d;
  logic               busy_q, busy_d;
  logic [31:0]        rData_q, rData_d;
  logic               grantB;

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lastGrantB_q <= 1'b0;
      sel_q        <= 1'b0;
      memEn_q      <= 1'b0;
      memWe_q      <= 1'b0;
      ackA_q       <= 1'b0;
      ackB_q       <= 1'b0;
      busy_q       <= 1'b0;
      rData_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lastGrantB_q <= lastGrantB_d;
      sel_q        <= sel_d;
      memEn_q      <= memEn_d;
      memWe_q      <= memWe_d;
      ackA_q       <= ackA_d;
      ackB_q       <= ackB_d;
      busy_q       <= busy_d;
      rData_q      <= rData_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, count down the access, pulse Ack in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lastGrantB_d = lastGrantB_q;
    sel_d        = sel_q;
    memEn_d      = memEn_q;
    memWe_d      = memWe_q;
    ackA_d       = 1'b0;
    ackB_d       = 1'b0;
    busy_d       = busy_q;
    rData_d      = rData_q;
    // B wins when it is alone, or when both wait and A had the previous grant.
    grantB       = ReqB && (!ReqA || !lastGrantB_q);

    case (state_q)
      IDLE: begin
        if (ReqA || ReqB) begin
          sel_d        = grantB;
          memEn_d      = 1'b1;
          memWe_d      = grantB && WeB;
          cnt_d        = CNT_W'(LATENCY - 1);
          lastGrantB_d = grantB;
          busy_d       = 1'b1;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!memWe_q) begin
            rData_d = MemRData;
          end
          memEn_d = 1'b0;
          memWe_d = 1'b0;
          ackA_d  = !sel_q;
          ackB_d  = sel_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        memEn_d = 1'b0;
        memWe_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign Sel   = sel_q;
  assign MemEn = memEn_q;
  assign MemWe = memWe_q;
  assign AckA  = ackA_q;
  assign AckB  = ackB_q;
  assign RData = rData_q;
  assign Busy  = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for the short-access sweep.
module tb_mem_port_arbiter;

  logic        Clk;
  logic        Rst;

  logic        reqA, reqB, weB;
  logic [31:0] memRData;
  logic        sel, memEn, memWe, ackA, ackB, busy;
  logic [31:0] rData;

  logic        reqA1, reqB1, weB1;
  logic [31:0] memRData1;
  logic        sel1, memEn1, memWe1, ackA1, ackB1, busy1;
  logic [31:0] rData1;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.LATENCY(2), .CNT_W(4)) dut2 (
    .Clk(Clk), .Rst(Rst), .ReqA(reqA), .ReqB(reqB), .WeB(weB),
    .MemRData(memRData), .Sel(sel), .MemEn(memEn), .MemWe(memWe),
    .AckA(ackA), .AckB(ackB), .RData(rData), .Busy(busy)
  );

  mem_port_arbiter #(.LATENCY(1), .CNT_W(4)) dut1 (
    .Clk(Clk), .Rst(Rst), .ReqA(reqA1), .ReqB(reqB1), .WeB(weB1),
    .MemRData(memRData1), .Sel(sel1), .MemEn(memEn1), .MemWe(memWe1),
    .AckA(ackA1), .AckB(ackB1), .RData(rData1), .Busy(busy1)
  );

  // Free-running 10-time-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance to just after the next rising edge: the start of a new cycle.
  task automatic nextCycle;
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset;
    Rst = 1'b0;
    nextCycle();
    nextCycle();
    Rst = 1'b1;
    nextCycle();
  endtask

  task automatic test_reset;
    Rst = 1'b0;
    #1;
    checks++;
    if ({sel, memEn, memWe, ackA, ackB, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {sel, memEn, memWe, ackA, ackB, busy});
    end
    checks++;
    if (rData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h expected 00000000", rData);
    end
    checks++;
    if ({memEn1, ackA1, ackB1, busy1} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_l1: got %b expected 0000", {memEn1, ackA1, ackB1, busy1});
    end
    nextCycle();
    nextCycle();
    Rst = 1'b1;
    nextCycle();
  endtask

  task automatic test_single_fetch;
    logic [1:4] enTab, ackTab, busyTab;
    enTab = 4'b1100; ackTab = 4'b0010; busyTab = 4'b1110;
    memRData = 32'h0;
    reqA = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      if (c == 2) memRData = 32'hDEADBEEF;
      checks++;
      if (memEn !== enTab[c] || ackA !== ackTab[c] || busy !== busyTab[c] ||
          sel !== 1'b0 || ackB !== 1'b0 || memWe !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fetch_cycle%0d: got en=%b ack=%b busy=%b sel=%b we=%b expected en=%b ack=%b busy=%b sel=0 we=0",
                 c, memEn, ackA, busy, sel, memWe, enTab[c], ackTab[c], busyTab[c]);
      end
      if (c >= 3) begin
        checks++;
        if (rData !== 32'hDEADBEEF) begin
          errors++;
          $display("[TB] FAIL fetch_rdata%0d: got %h expected deadbeef", c, rData);
        end
      end
      if (c == 3) reqA = 1'b0;
    end
  endtask

  task automatic test_contention;
    logic [1:8] enTab, selTab, ackATab, ackBTab;
    enTab = 8'b11001100; selTab = 8'b11110000;
    ackATab = 8'b00000010; ackBTab = 8'b00100000;
    doReset();
    weB = 1'b0;
    reqA = 1'b1;
    reqB = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      nextCycle();
      if (c == 2) memRData = 32'hB0B0B0B0;
      if (c == 6) memRData = 32'hA0A0A0A0;
      checks++;
      if (memEn !== enTab[c] || sel !== selTab[c] || ackA !== ackATab[c] || ackB !== ackBTab[c]) begin
        errors++;
        $display("[TB] FAIL contention_cycle%0d: got en=%b sel=%b ackA=%b ackB=%b expected en=%b sel=%b ackA=%b ackB=%b",
                 c, memEn, sel, ackA, ackB, enTab[c], selTab[c], ackATab[c], ackBTab[c]);
      end
      if (c == 3) begin
        checks++;
        if (rData !== 32'hB0B0B0B0) begin
          errors++;
          $display("[TB] FAIL contention_rdataB: got %h expected b0b0b0b0", rData);
        end
        reqB = 1'b0;
      end
      if (c == 7) begin
        checks++;
        if (rData !== 32'hA0A0A0A0) begin
          errors++;
          $display("[TB] FAIL contention_rdataA: got %h expected a0a0a0a0", rData);
        end
        reqA = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic expB;
    int   acks;
    doReset();
    weB = 1'b0;
    reqA = 1'b1;
    reqB = 1'b1;
    expB = 1'b1;
    acks = 0;
    for (int cyc = 0; cyc < 40 && acks < 4; cyc++) begin
      nextCycle();
      if (ackA || ackB) begin
        checks++;
        if (ackB !== expB || ackA !== !expB) begin
          errors++;
          $display("[TB] FAIL rr_grant%0d: got ackA=%b ackB=%b expected ackA=%b ackB=%b",
                   acks, ackA, ackB, !expB, expB);
        end
        expB = !expB;
        acks++;
      end
    end
    reqA = 1'b0;
    reqB = 1'b0;
    checks++;
    if (acks != 4) begin
      errors++;
      $display("[TB] FAIL rr_timeout: got %0d acks expected 4", acks);
    end
    nextCycle();
    nextCycle();
  endtask

  task automatic test_write;
    logic [1:4] enTab, ackTab;
    enTab = 4'b1100; ackTab = 4'b0010;
    memRData = 32'h12345678;
    reqA = 1'b1;
    nextCycle();
    nextCycle();
    nextCycle();
    reqA = 1'b0;
    checks++;
    if (rData !== 32'h12345678 || ackA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_preload: got rdata=%h ackA=%b expected 12345678 1", rData, ackA);
    end
    nextCycle();
    memRData = 32'hFFFFFFFF;
    reqB = 1'b1;
    weB = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      checks++;
      if (memEn !== enTab[c] || memWe !== enTab[c] || ackB !== ackTab[c] ||
          ackA !== 1'b0 || sel !== 1'b1 || rData !== 32'h12345678) begin
        errors++;
        $display("[TB] FAIL write_cycle%0d: got en=%b we=%b ackB=%b ackA=%b sel=%b rdata=%h expected en=%b we=%b ackB=%b ackA=0 sel=1 rdata=12345678",
                 c, memEn, memWe, ackB, ackA, sel, rData, enTab[c], enTab[c], ackTab[c]);
      end
      if (c == 3) begin
        reqB = 1'b0;
        weB = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_access;
    logic sawAck;
    reqB = 1'b1;
    weB = 1'b0;
    nextCycle();
    checks++;
    if (memEn !== 1'b1 || sel !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got en=%b sel=%b busy=%b expected 1 1 1", memEn, sel, busy);
    end
    #3;
    Rst = 1'b0;
    #1;
    checks++;
    if (memEn !== 1'b0 || busy !== 1'b0 || sel !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got en=%b busy=%b sel=%b expected 0 0 0", memEn, busy, sel);
    end
    reqB = 1'b0;
    nextCycle();
    Rst = 1'b1;
    sawAck = 1'b0;
    for (int c = 0; c < 6; c++) begin
      nextCycle();
      if (ackA || ackB || busy) sawAck = 1'b1;
    end
    checks++;
    if (sawAck !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_noack: got activity=%b expected 0", sawAck);
    end
  endtask

  task automatic test_latency1;
    logic [1:7] enTab, ackTab;
    enTab = 7'b1001001; ackTab = 7'b0100100;
    memRData1 = 32'h0;
    reqA1 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      nextCycle();
      checks++;
      if (memEn1 !== enTab[c] || ackA1 !== ackTab[c] || ackB1 !== 1'b0 || memWe1 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL lat1_cycle%0d: got en=%b ackA=%b ackB=%b we=%b expected en=%b ackA=%b ackB=0 we=0",
                 c, memEn1, ackA1, ackB1, memWe1, enTab[c], ackTab[c]);
      end
      if (c == 2) begin
        checks++;
        if (rData1 !== 32'h101) begin
          errors++;
          $display("[TB] FAIL lat1_rdata1: got %h expected 00000101", rData1);
        end
      end
      if (c == 5) begin
        checks++;
        if (rData1 !== 32'h104) begin
          errors++;
          $display("[TB] FAIL lat1_rdata2: got %h expected 00000104", rData1);
        end
      end
      memRData1 = 32'h100 + 32'(c);
    end
    reqA1 = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    Rst = 1'b0;
    reqA = 1'b0; reqB = 1'b0; weB = 1'b0; memRData = 32'h0;
    reqA1 = 1'b0; reqB1 = 1'b0; weB1 = 1'b0; memRData1 = 32'h0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_back_to_back();
    test_write();
    test_reset_mid_access();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
